// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC sequencer with return-address stack
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter int                IDX_W     = 26,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [1:0]        sel,
  input  logic              br_taken,
  input  logic [15:0]       imm,
  input  logic [IDX_W-1:0]  index,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              jal,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              misalign,
  output logic              ras_empty,
  output logic              ras_full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W:0]    count;

  logic [ADDR_W-1:0] nxt_pc;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] br_off;
  logic signed [17:0] br_off18;
  logic              use_rs;
  logic              do_push;
  logic              do_pop;

  assign pc_plus4  = pc + ADDR_W'(4);
  assign br_off18  = {imm, 2'b00};
  assign br_off    = ADDR_W'(br_off18);
  assign br_target = pc_plus4 + br_off;
  assign jr_target = {rs_val[ADDR_W-1:2], 2'b00};

  generate
    if (ADDR_W > IDX_W + 2) begin : g_jmp_upper
      assign jmp_target = {pc_plus4[ADDR_W-1:IDX_W+2], index, 2'b00};
    end else begin : g_jmp_flat
      assign jmp_target = {index, 2'b00};
    end
  endgenerate

  // wr_ptr is the next free slot; wrapping makes an overflowing push land on the oldest entry
  assign top_ptr   = wr_ptr - PTR_W'(1);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == (PTR_W+1)'(RAS_DEPTH));

  always_comb begin
    nxt_pc = pc_plus4;
    use_rs = 1'b0;
    if (ret && !ras_empty) begin
      nxt_pc = ras_mem[top_ptr];
    end else if (ret) begin
      nxt_pc = jr_target;
      use_rs = 1'b1;
    end else begin
      case (sel)
        2'b00: nxt_pc = pc_plus4;
        2'b01: nxt_pc = br_taken ? br_target : pc_plus4;
        2'b10: nxt_pc = jmp_target;
        default: begin
          nxt_pc = jr_target;
          use_rs = 1'b1;
        end
      endcase
    end
  end

  assign do_push = en && jal && !ret && sel[1];
  assign do_pop  = en && ret && !ras_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (en) begin
      pc <= nxt_pc;
      if (use_rs && (rs_val[1:0] != 2'b00)) begin
        misalign <= 1'b1;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (!ras_full) begin
          count <= count + 1'b1;
        end
      end else if (do_pop) begin
        wr_ptr <= top_ptr;
        count  <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && do_push) begin
      ras_mem[wr_ptr] <= pc_plus4;
    end
  end

endmodule
